// File: rtl/ecg_beat_ctrl.sv
// ecg_beat_ctrl
// ---------------------------------------------------------------------------
// Sequencer and output scheduler for the ECG QRS measurement datapath.
//
// Controls the sample stream into the datapath:
//   * The datapath is held in reset while disabled or flushing.
//   * Once running, it is fed one enable per sample.
//
// Beat processing:
//   * A learn/track/refractory state machine runs on detected R peaks.
//   * One beat record (RR interval, QRS width, plausibility flags) is
//     emitted per accepted beat.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-low reset
//   enable      in   level: 1 = run, 0 = stop (next state IDLE)
//   s_valid     in   one-cycle strobe per ECG sample
//   r_peak      in   R-peak pulse, honoured only with s_valid
//   qrs_w       in   current QRS width from the datapath
//   dp_ce       out  datapath sample enable (= s_valid while running)
//   dp_rst      out  active-high datapath reset (IDLE / FLUSH)
//   beat_valid  out  beat record available
//   beat_ready  in   consumer accepts the record
//   beat_rr     out  RR interval in samples
//   beat_qrs    out  QRS width captured at the peak
//   beat_flags  out  [0] short (rr < RR_MIN), [1] long (rr > RR_MAX or saturated)
//   drop_cnt    out  saturating count of records discarded under backpressure
//   rr_avg      out  mean of the last 8 emitted RR values (0 without RR_AVG_EN)
//   state       out  FSM state code: IDLE=0 FLUSH=1 LEARN=2 TRACK=3 REFRACT=4
//
// Optional feature
//   RR_AVG_EN   when defined, an 8-entry RR history drives rr_avg.
//               Otherwise, rr_avg is tied to 0.
//
// Handshake
//   The record transfers at a clock edge where beat_valid=1 and beat_ready=1.
//   beat_valid only falls after a transfer (or on reset).
//   Fields stay stable while beat_valid=1.
//   An emit that finds the register full, with no transfer in the same
//   cycle, is dropped and counted in drop_cnt.
//   An emit coinciding with a transfer replaces the outgoing record.
// ---------------------------------------------------------------------------
module ecg_beat_ctrl #(
  parameter int CNT_W       = 16,
  parameter int LEARN_BEATS = 2,
  parameter int REFRACT     = 50,
  parameter int RR_MIN      = 60,
  parameter int RR_MAX      = 500,
  parameter int FLUSH_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             s_valid,
  input  logic             r_peak,
  input  logic [CNT_W-1:0] qrs_w,
  output logic             dp_ce,
  output logic             dp_rst,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic [CNT_W-1:0] beat_rr,
  output logic [CNT_W-1:0] beat_qrs,
  output logic [1:0]       beat_flags,
  output logic [7:0]       drop_cnt,
  output logic [CNT_W-1:0] rr_avg,
  output logic [2:0]       state
);

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  localparam int FL_W = (FLUSH_CYC   > 1) ? $clog2(FLUSH_CYC + 1)   : 1;
  localparam int RF_W = (REFRACT     > 1) ? $clog2(REFRACT + 1)     : 1;
  localparam int PK_W = (LEARN_BEATS > 1) ? $clog2(LEARN_BEATS + 1) : 1;

  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYC - 1);
  localparam logic [RF_W-1:0]  REF_LAST   = RF_W'(REFRACT - 1);
  localparam logic [PK_W-1:0]  LEARN_LAST = PK_W'(LEARN_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] RR_MIN_C   = CNT_W'(RR_MIN);
  localparam logic [CNT_W-1:0] RR_MAX_C   = CNT_W'(RR_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_LEARN   = 3'd2,
    ST_TRACK   = 3'd3,
    ST_REFRACT = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  state_t           cur_st;
  state_t           nxt_st;

  logic [FL_W-1:0]  flush_cnt;
  logic [RF_W-1:0]  ref_cnt;
  logic [PK_W-1:0]  peak_cnt;
  logic [CNT_W-1:0] rr_cnt;

  logic             running;
  logic             accept;
  logic             emit;
  logic             rr_sat;
  logic [CNT_W-1:0] rr_val;
  logic             flag_short;
  logic             flag_long;

  assign state = cur_st;

  // -------------------------------------------------------------------------
  // Peak qualification and RR arithmetic
  // -------------------------------------------------------------------------
  assign running = (cur_st == ST_LEARN) || (cur_st == ST_TRACK) ||
                   (cur_st == ST_REFRACT);

  // Peaks count only in LEARN and TRACK; REFRACT ignores them entirely.
  assign accept = s_valid && r_peak &&
                  ((cur_st == ST_LEARN) || (cur_st == ST_TRACK));
  assign emit   = accept && (cur_st == ST_TRACK);

  // rr includes the peak sample itself, so it is counter+1.
  // A saturated counter also pins rr at its maximum and is reported as long.
  assign rr_sat     = (rr_cnt == CNT_MAX);
  assign rr_val     = rr_sat ? CNT_MAX : rr_cnt + 1'b1;
  assign flag_short = (rr_val < RR_MIN_C);
  assign flag_long  = (rr_val > RR_MAX_C) || rr_sat;

  // -------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: begin
        if (enable) nxt_st = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) nxt_st = ST_LEARN;
      end
      ST_LEARN: begin
        if (accept && (peak_cnt == LEARN_LAST)) nxt_st = ST_TRACK;
      end
      ST_TRACK: begin
        if (accept) nxt_st = ST_REFRACT;
      end
      ST_REFRACT: begin
        if (s_valid && (ref_cnt == REF_LAST)) nxt_st = ST_TRACK;
      end
      default: nxt_st = ST_IDLE;
    endcase
    // Disable wins from every state.
    if (!enable) nxt_st = ST_IDLE;
  end

  always_comb begin
    dp_rst = 1'b1;
    dp_ce  = 1'b0;
    if (running) begin
      dp_rst = 1'b0;
      dp_ce  = s_valid;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register and sequencing counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st    <= ST_IDLE;
      flush_cnt <= '0;
      ref_cnt   <= '0;
      peak_cnt  <= '0;
      rr_cnt    <= '0;
    end else begin
      cur_st <= nxt_st;

      if (running) begin
        flush_cnt <= '0;

        // RR counter runs through REFRACT too.
        // Only an accepted peak restarts it.
        if (s_valid) begin
          if (accept) begin
            rr_cnt <= '0;
          end else if (!rr_sat) begin
            rr_cnt <= rr_cnt + 1'b1;
          end
        end

        if (accept && (cur_st == ST_LEARN)) begin
          peak_cnt <= peak_cnt + 1'b1;
        end

        if (emit) begin
          ref_cnt <= '0;
        end else if ((cur_st == ST_REFRACT) && s_valid) begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end else begin
        // IDLE and FLUSH: everything but the flush timer sits at zero.
        rr_cnt    <= '0;
        peak_cnt  <= '0;
        ref_cnt   <= '0;
        flush_cnt <= (cur_st == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // One-deep beat output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_valid <= 1'b0;
      beat_rr    <= '0;
      beat_qrs   <= '0;
      beat_flags <= '0;
      drop_cnt   <= '0;
    end else if (emit) begin
      if (beat_valid && !beat_ready) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else begin
        beat_valid <= 1'b1;
        beat_rr    <= rr_val;
        beat_qrs   <= qrs_w;
        beat_flags <= {flag_long, flag_short};
      end
    end else if (beat_valid && beat_ready) begin
      beat_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // RR running mean
  // -------------------------------------------------------------------------
`ifdef RR_AVG_EN
  logic [CNT_W-1:0] rr_hist [8];
  logic [CNT_W+2:0] rr_sum;

  // History advances on every emit, including records later dropped by
  // the output register, so the mean tracks the rhythm, not the consumer.
  always_ff @(posedge clk) begin
    if (!rst || (cur_st == ST_FLUSH)) begin
      for (int i = 0; i < 8; i++) rr_hist[i] <= '0;
    end else if (emit) begin
      rr_hist[0] <= rr_val;
      for (int i = 1; i < 8; i++) rr_hist[i] <= rr_hist[i-1];
    end
  end

  always_comb begin
    rr_sum = '0;
    for (int i = 0; i < 8; i++) begin
      rr_sum = rr_sum + {3'b000, rr_hist[i]};
    end
  end

  assign rr_avg = rr_sum[CNT_W+2:3];
`else
  assign rr_avg = '0;
`endif

endmodule

// File: tb/tb_ecg_beat_ctrl.sv
// Directed testbench for ecg_beat_ctrl.
// REFRACT is shortened to 35 samples so that a peak 40 samples after an
// accepted beat lands in TRACK (refractory window = samples 1..35).
module tb_ecg_beat_ctrl;

  localparam int CNT_W = 16;

`ifdef RR_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic             enable;
  logic             s_valid;
  logic             r_peak;
  logic [CNT_W-1:0] qrs_w;
  logic             dp_ce;
  logic             dp_rst;
  logic             beat_valid;
  logic             beat_ready;
  logic [CNT_W-1:0] beat_rr;
  logic [CNT_W-1:0] beat_qrs;
  logic [1:0]       beat_flags;
  logic [7:0]       drop_cnt;
  logic [CNT_W-1:0] rr_avg;
  logic [2:0]       state;

  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ecg_beat_ctrl #(
    .CNT_W      (CNT_W),
    .LEARN_BEATS(2),
    .REFRACT    (35),
    .RR_MIN     (60),
    .RR_MAX     (500),
    .FLUSH_CYC  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .s_valid   (s_valid),
    .r_peak    (r_peak),
    .qrs_w     (qrs_w),
    .dp_ce     (dp_ce),
    .dp_rst    (dp_rst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_rr   (beat_rr),
    .beat_qrs  (beat_qrs),
    .beat_flags(beat_flags),
    .drop_cnt  (drop_cnt),
    .rr_avg    (rr_avg),
    .state     (state)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge.
  // Outputs are read at the same point, so they show the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n consecutive samples (one per cycle); r_peak only on the last when pk_last.
  task automatic run_samples(input int n, input logic pk_last);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      r_peak  = pk_last && (i == n - 1);
      tick();
    end
    s_valid = 1'b0;
    r_peak  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    s_valid    = 1'b0;
    r_peak     = 1'b0;
    qrs_w      = '0;
    beat_ready = 1'b0;

    // Reset and idle
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_dp_rst", 32'(dp_rst), 1);
    check("rst_dp_ce", 32'(dp_ce), 0);
    check("rst_valid", 32'(beat_valid), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_rr", 32'(beat_rr), 0);
    check("rst_avg", 32'(rr_avg), 0);
    rst = 1'b1;
    tick();
    check("idle_hold", 32'(state), 0);

    // Enable -> FLUSH for 4 cycles -> LEARN
    enable = 1'b1;
    tick();
    check("flush_enter", 32'(state), 1);
    check("flush_dp_rst", 32'(dp_rst), 1);
    tick();
    tick();
    tick();
    check("flush_4th", 32'(state), 1);
    tick();
    check("learn_enter", 32'(state), 2);
    check("learn_dp_rst", 32'(dp_rst), 0);
    check("learn_ce_lo", 32'(dp_ce), 0);
    s_valid = 1'b1;
    #1;
    check("learn_ce_hi", 32'(dp_ce), 1);
    s_valid = 1'b0;

    // Learn then track: peaks at samples 10, 110, 210
    qrs_w = 16'd37;
    run_samples(11, 1'b1);
    check("learn1_state", 32'(state), 2);
    check("learn1_valid", 32'(beat_valid), 0);
    run_samples(100, 1'b1);
    check("learn2_state", 32'(state), 3);
    check("learn2_valid", 32'(beat_valid), 0);
    run_samples(100, 1'b1);
    check("beat1_valid", 32'(beat_valid), 1);
    check("beat1_rr", 32'(beat_rr), 100);
    check("beat1_qrs", 32'(beat_qrs), 37);
    check("beat1_flags", 32'(beat_flags), 0);
    check("beat1_state", 32'(state), 4);
    beat_ready = 1'b1;
    tick();
    beat_ready = 1'b0;
    check("beat1_taken", 32'(beat_valid), 0);

    // Refractory: peak 30 samples later ignored, next at 40 is short
    run_samples(30, 1'b1);
    check("refr_ignored", 32'(beat_valid), 0);
    check("refr_state", 32'(state), 4);
    run_samples(10, 1'b1);
    check("short_valid", 32'(beat_valid), 1);
    check("short_rr", 32'(beat_rr), 40);
    check("short_flags", 32'(beat_flags), 1);
    beat_ready = 1'b1;
    tick();
    beat_ready = 1'b0;

    // Long gap of 600 samples
    run_samples(600, 1'b1);
    check("long_rr", 32'(beat_rr), 600);
    check("long_flags", 32'(beat_flags), 2);
    beat_ready = 1'b1;
    tick();
    beat_ready = 1'b0;

    // Backpressure: three emits with beat_ready low
    qrs_w = 16'd11;
    run_samples(100, 1'b1);
    check("bp1_valid", 32'(beat_valid), 1);
    check("bp1_rr", 32'(beat_rr), 100);
    qrs_w = 16'd22;
    run_samples(120, 1'b1);
    check("bp2_drop", 32'(drop_cnt), 1);
    check("bp2_rr_held", 32'(beat_rr), 100);
    qrs_w = 16'd33;
    run_samples(140, 1'b1);
    check("bp3_drop", 32'(drop_cnt), 2);
    check("bp3_rr_held", 32'(beat_rr), 100);
    check("bp3_qrs_held", 32'(beat_qrs), 11);
    check("bp3_valid", 32'(beat_valid), 1);
    // Ready for one cycle coinciding with a new emit
    qrs_w = 16'd44;
    run_samples(89, 1'b0);
    beat_ready = 1'b1;
    run_samples(1, 1'b1);
    beat_ready = 1'b0;
    check("swap_valid", 32'(beat_valid), 1);
    check("swap_rr", 32'(beat_rr), 90);
    check("swap_qrs", 32'(beat_qrs), 44);
    check("swap_drop", 32'(drop_cnt), 2);

    // Disable in REFRACT with a record pending
    enable = 1'b0;
    tick();
    check("dis_state", 32'(state), 0);
    check("dis_dp_rst", 32'(dp_rst), 1);
    check("dis_valid", 32'(beat_valid), 1);
    tick();
    check("dis_valid2", 32'(beat_valid), 1);
    check("dis_rr", 32'(beat_rr), 90);
    beat_ready = 1'b1;
    tick();
    check("dis_taken", 32'(beat_valid), 0);

    // Re-enable: flush clears history; eight rr=100 beats then rr=180
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("re_learn", 32'(state), 2);
    run_samples(5, 1'b1);
    run_samples(100, 1'b1);
    check("re_track", 32'(state), 3);
    for (int i = 0; i < 8; i++) begin
      run_samples(100, 1'b1);
      check("avg_beat_rr", 32'(beat_rr), 100);
      if (i == 3) check("avg_half", 32'(rr_avg), AVG_ON ? 50 : 0);
    end
    check("avg_100", 32'(rr_avg), AVG_ON ? 100 : 0);
    run_samples(179, 1'b0);
    beat_ready = 1'b0;
    run_samples(1, 1'b1);
    check("avg_last_rr", 32'(beat_rr), 180);
    check("avg_110", 32'(rr_avg), AVG_ON ? 110 : 0);
    check("avg_drop", 32'(drop_cnt), 2);
    check("avg_valid", 32'(beat_valid), 1);

    // Reset with a record pending discards it
    rst = 1'b0;
    tick();
    check("rst2_valid", 32'(beat_valid), 0);
    check("rst2_state", 32'(state), 0);
    check("rst2_drop", 32'(drop_cnt), 0);
    check("rst2_rr", 32'(beat_rr), 0);
    check("rst2_avg", 32'(rr_avg), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
